scale_arb: RTL and testbench

SCALE_ARB -- requirements
Module: scale_arb

---
 rtl/scale_pkg.sv | 24 ++
 rtl/scale_arb_if.sv | 27 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/scale_arb.sv | 128 ++++++++++++
 tb/tb_scale_arb.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scale_pkg.sv
// Shared types and constants for the round-robin scaler arbiter.
package scale_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 14;

  // Gain 0.40625 = 2^-2 + 2^-3 + 2^-5
  localparam int unsigned SH_A = 2;
  localparam int unsigned SH_B = 3;
  localparam int unsigned SH_C = 5;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    ACC2,
    DONE
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scale_arb_if.sv
// Requester-side bundle between the requesters and the shared scaler.
interface scale_arb_if
  import scale_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] din;
  logic                    bypass;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       result;
  logic                    busy;

  modport master (
    output req, din, bypass,
    input  gnt, ack, result, busy
  );

  modport slave (
    input  req, din, bypass,
    output gnt, ack, result, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_oh_c_o,
  output logic [PTR_W-1:0] win_idx_c_o
);

  int unsigned pos;
  logic        found;

  always_comb begin
    win_oh_c_o  = '0;
    win_idx_c_o = '0;
    found       = 1'b0;
    pos         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!found && req_i[PTR_W'(pos)]) begin
        found                    = 1'b1;
        win_oh_c_o[PTR_W'(pos)]  = 1'b1;
        win_idx_c_o              = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/scale_arb.sv
// Shared fixed-gain (0.40625) scaler with round-robin arbitration between requesters.
module scale_arb
  import scale_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  scale_arb_if.slave  bus
);

  localparam int unsigned ACC_W = DATA_W + 1;
  localparam int unsigned PTR_W = idx_w(N_REQ);

  state_e                    state_q, state_d;
  logic [N_REQ-1:0]          gnt_q, gnt_d;
  logic [N_REQ-1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]         result_q, result_d;
  logic                      busy_q, busy_d;
  logic signed [DATA_W-1:0]  op_q, op_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;

  logic [N_REQ-1:0]          win_oh;
  logic [PTR_W-1:0]          win_idx;
  logic [PTR_W-1:0]          ptr_nxt;
  logic signed [DATA_W-1:0]  win_din;
  logic signed [ACC_W-1:0]   op_ext;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i       (bus.req),
    .ptr_i       (ptr_q),
    .win_oh_c_o  (win_oh),
    .win_idx_c_o (win_idx)
  );

  // Operand slice of the current winner
  always_comb begin
    win_din = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win_oh[i]) win_din = bus.din[i*DATA_W +: DATA_W];
    end
  end

  assign ptr_nxt = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
  assign op_ext  = {op_q[DATA_W-1], op_q};

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    result_d = result_q;
    op_d     = op_q;
    acc_d    = acc_q;
    ptr_d    = ptr_q;

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d = win_oh;
          op_d  = win_din;
          ptr_d = ptr_nxt;
          if (bus.bypass) begin
            ack_d    = win_oh;
            result_d = win_din;
            state_d  = DONE;
          end else begin
            state_d  = ACC0;
          end
        end
      end
      ACC0: begin
        acc_d   = op_ext >>> SH_A;
        state_d = ACC1;
      end
      ACC1: begin
        acc_d   = acc_q + (op_ext >>> SH_B);
        state_d = ACC2;
      end
      // Final term lands in result together with ack on entry to DONE
      ACC2: begin
        acc_d    = acc_q + (op_ext >>> SH_C);
        result_d = acc_d[DATA_W-1:0];
        ack_d    = gnt_q;
        state_d  = DONE;
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      op_q     <= '0;
      acc_q    <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_scale_arb.sv
// Self-checking bench for scale_arb: vector table, scoreboard and corner sequences.
module tb_scale_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 14;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  scale_arb_if #(.N_REQ(NR), .DATA_W(DW)) bus ();

  scale_arb #(.N_REQ(NR), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] oh;
    int            res;
  } exp_t;

  typedef struct {
    int idx;
    bit byp;
    int din;
    int res;
    int lat;
  } vec_t;

  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int fdiv(input int v, input int d);
    int q;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic int model(input int v, input bit byp);
    if (byp) return v;
    return fdiv(v, 4) + fdiv(v, 8) + fdiv(v, 32);
  endfunction

  // Scoreboard: every ack pops one expectation
  always @(negedge clk) begin
    if (!rst && bus.ack != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", longint'(bus.ack), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_onehot", longint'(bus.ack), longint'(e.oh));
        chk("result", longint'($signed(bus.result)), longint'(e.res));
      end
    end
  end

  task automatic set_din(input int idx, input int val);
    bus.din[idx*DW +: DW] = DW'(val);
  endtask

  task automatic wait_ack(input int budget, output bit got, output int when);
    got  = 1'b0;
    when = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        got  = 1'b1;
        when = cyc;
        break;
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    bus.req    = '0;
    bus.bypass = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", longint'(bus.gnt), 0);
    chk("rst_ack", longint'(bus.ack), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_result", longint'(bus.result), 0);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit   got;
    int   c0, ca;
    exp_t e;
    logic [NR-1:0] oh;
    @(negedge clk);
    oh         = '0;
    oh[v.idx]  = 1'b1;
    set_din(v.idx, v.din);
    bus.bypass = v.byp;
    bus.req    = oh;
    e.oh = oh;
    e.res = v.res;
    sb.push_back(e);
    c0 = cyc;
    wait_ack(20, got, ca);
    if (got) begin
      chk("latency", ca - c0, v.lat);
      chk("gnt_at_ack", longint'(bus.gnt), longint'(oh));
    end
    bus.req    = '0;
    bus.bypass = 1'b0;
    @(negedge clk);
    chk("idle_gnt", longint'(bus.gnt), 0);
    chk("idle_busy", longint'(bus.busy), 0);
  endtask

  vec_t vecs[$];
  int   dcont[4];

  initial begin
    bit   got;
    int   c0, ca, prev;
    exp_t e;

    rst        = 1'b1;
    bus.req    = '0;
    bus.din    = '0;
    bus.bypass = 1'b0;

    vecs.push_back('{1, 1'b0,  1000,   406, 4});
    vecs.push_back('{0, 1'b0, -1000,  -407, 4});
    vecs.push_back('{2, 1'b0,  8191,  3325, 4});
    vecs.push_back('{3, 1'b0, -8192, -3328, 4});
    vecs.push_back('{2, 1'b1,   -77,   -77, 1});
    vecs.push_back('{3, 1'b0,     0,     0, 4});
    vecs.push_back('{1, 1'b1,  8191,  8191, 1});
    vecs.push_back('{0, 1'b0,     1,     0, 4});
    vecs.push_back('{0, 1'b0,    -1,    -3, 4});

    do_reset();

    // Busy must rise right after the capture edge
    @(negedge clk);
    bus.req = 4'b0010;
    set_din(1, 1000);
    e.oh = 4'b0010;
    e.res = 406;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_after_capture", longint'(bus.busy), 1);
    chk("gnt_after_capture", longint'(bus.gnt), 4'b0010);
    wait_ack(20, got, ca);
    bus.req = '0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention: all four held, round-robin 0,1,2,3,0 one per 5 cycles
    do_reset();
    dcont = '{100, -200, 3000, -4096};
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_din(i, dcont[i]);
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      e.oh = '0;
      e.oh[i % 4] = 1'b1;
      e.res = model(dcont[i % 4], 1'b0);
      sb.push_back(e);
    end
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_ack(20, got, ca);
      if (got && i > 0) chk("contention_spacing", ca - prev, 5);
      prev = ca;
    end
    bus.req = '0;
    @(negedge clk);

    // Back-to-back bypass: one ack every 2 cycles
    @(negedge clk);
    set_din(2, -77);
    bus.bypass = 1'b1;
    bus.req    = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      e.oh = 4'b0100;
      e.res = -77;
      sb.push_back(e);
    end
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_ack(10, got, ca);
      if (got && i > 0) chk("bypass_spacing", ca - prev, 2);
      prev = ca;
    end
    bus.req    = '0;
    bus.bypass = 1'b0;
    @(negedge clk);

    // Reset during ACC1 after granting index 2: no ack, pointer back to 0
    @(negedge clk);
    set_din(2, 500);
    bus.req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    bus.req = '0;
    rst     = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", longint'(bus.gnt), 0);
    chk("midrst_busy", longint'(bus.busy), 0);
    chk("midrst_result", longint'(bus.result), 0);
    rst = 1'b0;
    c0 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.ack != '0) c0++;
    end
    chk("midrst_no_ack", c0, 0);

    set_din(1, 1000);
    set_din(3, -1000);
    bus.req = 4'b1010;
    e.oh = 4'b0010;
    e.res = 406;
    sb.push_back(e);
    e.oh = 4'b1000;
    e.res = -407;
    sb.push_back(e);
    @(negedge clk);
    chk("post_rst_gnt", longint'(bus.gnt), 4'b0010);
    wait_ack(20, got, ca);
    bus.req = 4'b1000;
    wait_ack(20, got, ca);
    bus.req = '0;
    @(negedge clk);

    // Operand, bypass and req change during ACC0 must not disturb the op
    @(negedge clk);
    set_din(0, 1234);
    bus.req = 4'b0001;
    e.oh = 4'b0001;
    e.res = model(1234, 1'b0);
    sb.push_back(e);
    c0 = cyc;
    @(negedge clk);
    set_din(0, -5000);
    bus.req    = '0;
    bus.bypass = 1'b1;
    wait_ack(20, got, ca);
    if (got) chk("dropped_req_latency", ca - c0, 4);
    bus.bypass = 1'b0;

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule
